pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with a valid/ready handshake, an optional
//  2-entry skid buffer, synchronous flush and bubble zeroing. It carries a packed
//  inter-stage payload (e.g. ALU result | read data | rd | PC+4 = 101 bits) and
//  sits between any two stages of the RISC-V pipeline. Unlike a plain DFF bank,
//  it supports stall (backpressure) and flush while keeping full throughput.
// PARAMETERS
//  DATA_W      101  payload width in bits (packed fields, MSB-first per stage def)
//  SKID        1    1: 2-entry skid buffer with registered in_ready; 0: 1 entry,
//                   combinational in_ready
//  BUBBLE_ZERO 1    1: out_data forced to 0 whenever out_valid=0; 0: stale data held
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept; transfer = in_valid & in_ready
//  in_data    in   DATA_W  upstream payload
//  flush      in   1       sync kill: empties stage (branch mispredict / trap)
//  out_valid  out  1       downstream payload valid
//  out_ready  in   1       downstream accepts; transfer = out_valid & out_ready
//  out_data   out  DATA_W  registered payload to next stage
//  occupancy  out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Reset (sync, highest priority): out_valid=0, out_data=0, skid entry invalid
//    and zeroed, occupancy=0, in_ready=1. Registers change only on clk rising edge.
//  - Latency: 1 cycle in_data -> out_data. Throughput: 1 transfer/cycle when
//    out_ready is held at 1.
//  - Hold rule: while out_valid=1 & out_ready=0, out_data and out_valid are stable.
//  - SKID=1 states (occupancy): EMPTY(0), ONE(1), FULL(2); in_ready = ~skid_valid (reg).
//    EMPTY: in fire -> ONE, main<=in_data.
//    ONE:   in & out fire -> ONE, main<=in_data; in only -> FULL, skid<=in_data;
//           out only -> EMPTY.
//    FULL:  in_ready=0; out fire -> ONE, main<=skid, skid cleared; else hold.
//    Order is preserved: the skid entry always leaves after the main entry.
//  - SKID=0: single entry; in_ready = ~out_valid | out_ready (combinational);
//    in fire -> main<=in_data, out_valid=1; out fire w/o in fire -> out_valid=0.
//  - flush=1 (below reset, above everything else): next state EMPTY, occupancy=0;
//    payload accepted that cycle is discarded; out fire that cycle counts as
//    delivered; in_ready=1 the next cycle.
//  - BUBBLE_ZERO=1: every invalidation (out fire to EMPTY, flush, reset) zeroes
//    the freed entry, so a bubble reads rd=0 (x0, no hazard/writeback effect).
//  - occupancy is registered and always equals out_valid + skid_valid.
//  - No X propagation: all state is reset; in_data is sampled only on in fire.
// TESTING
//  1 reset high 2 cycles, in_valid=1 -> out_valid=0, out_data=0, in_ready=1, occ=0.
//  2 out_ready=1, stream 0x1..0x8 one per cycle -> same values one cycle later,
//    no gaps, occ stays 1.
//  3 SKID=1: send 0xA,0xB with out_ready=0 -> occ=2, in_ready=0, out_data=0xA
//    held; out_ready=1 -> 0xA then 0xB, in_ready returns to 1.
//  4 FULL (0xA,0xB) + flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0,
//    out_data=0, occ=0, 0xC never appears at the output.
//  5 SKID=0: out_ready=0 with 0x5 held -> in_ready=0; out_ready=1 & in 0x6 in the
//    same cycle -> 0x6 is registered, no bubble.
//  6 reset asserted while FULL -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake. It has an optional
//   second (skid) entry so that in_ready can come straight from a register.
//   It also has a synchronous flush and optional zeroing of bubbles.
//
//   State  | meaning
//   EMPTY  | nothing held, out_valid=0
//   ONE    | main entry valid, skid entry empty
//   FULL   | main and skid entries valid, in_ready=0 (SKID=1 only)
//
// Parameters
//   DATA_W      payload width
//   SKID        1: 2 entries, in_ready registered; 0: 1 entry, combinational in_ready
//   BUBBLE_ZERO 1: freed main entry is zeroed so out_data=0 whenever out_valid=0
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_data payload
//   flush                synchronous kill of all held entries
//   out_valid/out_ready  downstream handshake, out_data payload
//   occupancy            number of held entries (0..2)
module pipe_stage_skid #(
  parameter int DATA_W      = 101,
  parameter int SKID        = 1,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_nxt;
  logic [DATA_W-1:0] skid_data, skid_nxt;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign occupancy = state;

  // With a skid entry, in_ready depends only on registered state. Without one,
  // a draining downstream lets a new word in during the same cycle.
  assign in_ready = (SKID != 0) ? (state != FULL) : (~out_valid | out_ready);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    if (flush) begin
      // A word accepted in this cycle is dropped. A word delivered in this
      // cycle has already left.
      state_nxt = EMPTY;
      skid_nxt  = '0;
      if (BUBBLE_ZERO != 0) main_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            if (BUBBLE_ZERO != 0) main_nxt = '0;
          end
        end
        FULL: begin
          // The skid word is younger, so it moves up only after main leaves.
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_data;
            skid_nxt  = '0;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid. It uses two instances that share the clock
// and reset: "a" has the skid entry (SKID=1) and "b" has a single entry
// (SKID=0). Each instance has its own queue model.
module tb_pipe_stage_skid;
  localparam int W = 101;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  logic         in_valid_a = 1'b0, in_ready_a, flush_a = 1'b0;
  logic         out_valid_a, out_ready_a = 1'b0;
  logic [W-1:0] in_data_a = '0, out_data_a;
  logic [1:0]   occ_a;

  logic         in_valid_b = 1'b0, in_ready_b, flush_b = 1'b0;
  logic         out_valid_b, out_ready_b = 1'b0;
  logic [W-1:0] in_data_b = '0, out_data_b;
  logic [1:0]   occ_b;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .SKID(1), .BUBBLE_ZERO(1)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .flush(flush_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .occupancy(occ_a)
  );

  pipe_stage_skid #(.DATA_W(W), .SKID(0), .BUBBLE_ZERO(1)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .flush(flush_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .occupancy(occ_b)
  );

  // Reference model as a FIFO view. Entry a holds up to 2 words and accepts
  // while it is not full. Entry b holds 1 word and accepts while empty or
  // while draining.
  task automatic tick();
    bit ia, oa, ib, ob;
    logic [W-1:0] da, db;
    ia = in_valid_a && (qa.size() < 2);
    oa = out_ready_a && (qa.size() > 0);
    ib = in_valid_b && ((qb.size() == 0) || out_ready_b);
    ob = out_ready_b && (qb.size() > 0);
    da = in_data_a;
    db = in_data_b;
    @(posedge clk);
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (flush_a) qa.delete();
      else begin
        if (oa) void'(qa.pop_front());
        if (ia) qa.push_back(da);
      end
      if (flush_b) qb.delete();
      else begin
        if (ob) void'(qb.pop_front());
        if (ib) qb.push_back(db);
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid_a = 1'b1; in_data_a = 'h77; in_valid_b = 1'b1; in_data_b = 'h77;
    tick(); tick();
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b exp 0", out_valid_a); end
    checks++; if (out_data_a !== '0) begin failures++; $display("FAIL reset_out_data got %h exp 0", out_data_a); end
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b exp 1", in_ready_a); end
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL reset_occ got %0d exp 0", occ_a); end
    checks++; if (out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got %0b exp 0", out_valid_b); end
    reset = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    out_ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_a = 1'b1; in_data_a = W'(i);
      tick();
      checks++; if (out_valid_a !== 1'b1 || out_data_a !== W'(i)) begin failures++; $display("FAIL stream_data[%0d] got v=%0b d=%h exp v=1 d=%h", i, out_valid_a, out_data_a, W'(i)); end
      checks++; if (occ_a !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occ_a); end
    end
    in_valid_a = 1'b0;
    tick();
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== '0) begin failures++; $display("FAIL stream_bubble got v=%0b d=%h exp v=0 d=0", out_valid_a, out_data_a); end
  endtask

  task automatic test_skid();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'hA; tick();
    in_data_a = 'hB; tick();
    in_valid_a = 1'b0;
    checks++; if (occ_a !== 2'd2) begin failures++; $display("FAIL skid_occ_full got %0d exp 2", occ_a); end
    checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL skid_in_ready_full got %0b exp 0", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== W'('hA)) begin failures++; $display("FAIL skid_hold got v=%0b d=%h exp v=1 d=a", out_valid_a, out_data_a); end
    out_ready_a = 1'b1;
    tick();
    checks++; if (out_data_a !== W'('hB) || occ_a !== 2'd1) begin failures++; $display("FAIL skid_second got d=%h occ=%0d exp d=b occ=1", out_data_a, occ_a); end
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL skid_in_ready_back got %0b exp 1", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin failures++; $display("FAIL skid_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid_a, occ_a); end
  endtask

  task automatic test_flush();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'hA; tick();
    in_data_a = 'hB; tick();
    in_data_a = 'hC; flush_a = 1'b1; tick();
    flush_a = 1'b0; in_valid_a = 1'b0;
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== '0 || occ_a !== 2'd0) begin failures++; $display("FAIL flush_state got v=%0b d=%h occ=%0d exp 0 0 0", out_valid_a, out_data_a, occ_a); end
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %0b exp 1", in_ready_a); end
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL flush_leak[%0d] got v=%0b d=%h exp v=0", i, out_valid_a, out_data_a); end
    end
  endtask

  task automatic test_no_skid();
    out_ready_b = 1'b0;
    in_valid_b = 1'b1; in_data_b = 'h5; tick();
    in_valid_b = 1'b0; #1;
    checks++; if (out_data_b !== W'('h5) || in_ready_b !== 1'b0) begin failures++; $display("FAIL noskid_hold got d=%h rdy=%0b exp d=5 rdy=0", out_data_b, in_ready_b); end
    out_ready_b = 1'b1; in_valid_b = 1'b1; in_data_b = 'h6; #1;
    checks++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL noskid_comb_ready got %0b exp 1", in_ready_b); end
    tick();
    checks++; if (out_valid_b !== 1'b1 || out_data_b !== W'('h6) || occ_b !== 2'd1) begin failures++; $display("FAIL noskid_passthru got v=%0b d=%h occ=%0d exp 1 6 1", out_valid_b, out_data_b, occ_b); end
    in_valid_b = 1'b0;
    tick();
    checks++; if (out_valid_b !== 1'b0 || out_data_b !== '0) begin failures++; $display("FAIL noskid_drain got v=%0b d=%h exp 0 0", out_valid_b, out_data_b); end
  endtask

  task automatic test_reset_full();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'hA; tick();
    in_data_a = 'hB; tick();
    in_valid_a = 1'b0;
    checks++; if (occ_a !== 2'd2) begin failures++; $display("FAIL rstfull_pre got occ=%0d exp 2", occ_a); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== '0 || occ_a !== 2'd0 || in_ready_a !== 1'b1)
      begin failures++; $display("FAIL rstfull got v=%0b d=%h occ=%0d rdy=%0b exp 0 0 0 1", out_valid_a, out_data_a, occ_a, in_ready_a); end
  endtask

  task automatic test_random();
    logic [W-1:0] ea, eb;
    for (int c = 0; c < 400; c++) begin
      in_valid_a  = 1'($urandom_range(0, 1));
      out_ready_a = ($urandom_range(0, 3) != 0);
      flush_a     = ($urandom_range(0, 15) == 0);
      in_data_a   = rnd_data();
      in_valid_b  = 1'($urandom_range(0, 1));
      out_ready_b = ($urandom_range(0, 3) != 0);
      flush_b     = ($urandom_range(0, 15) == 0);
      in_data_b   = rnd_data();
      #1;
      ea = (qa.size() > 0) ? qa[0] : '0;
      eb = (qb.size() > 0) ? qb[0] : '0;
      checks++; if (out_valid_a !== (qa.size() > 0) || out_data_a !== ea || occ_a !== 2'(qa.size()) || in_ready_a !== (qa.size() < 2))
        begin failures++; $display("FAIL rand_a[%0d] got v=%0b d=%h occ=%0d rdy=%0b exp occ=%0d d=%h", c, out_valid_a, out_data_a, occ_a, in_ready_a, qa.size(), ea); end
      checks++; if (out_valid_b !== (qb.size() > 0) || out_data_b !== eb || occ_b !== 2'(qb.size()) || in_ready_b !== ((qb.size() == 0) || out_ready_b))
        begin failures++; $display("FAIL rand_b[%0d] got v=%0b d=%h occ=%0d rdy=%0b exp occ=%0d d=%h", c, out_valid_b, out_data_b, occ_b, in_ready_b, qb.size(), eb); end
      tick();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_no_skid();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
